// File: rtl/add_arbiter.sv
// add_arbiter: two-requester round-robin arbiter in front of a registered
// 8-bit two's-complement adder with signed-overflow detection and a
// saturating overflow event counter. Requesters use a 4-phase handshake.
module add_arbiter #(
    parameter int unsigned OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [7:0]           inp1_0,
    input  logic [7:0]           inp2_0,
    input  logic [7:0]           inp1_1,
    input  logic [7:0]           inp2_1,
    output logic                 done0,
    output logic                 done1,
    output logic [7:0]           sum,
    output logic                 overflow_flag,
    output logic                 gnt_id,
    output logic                 busy,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [7:0]           op1_q, op1_d;
    logic [7:0]           op2_q, op2_d;
    logic [7:0]           sum_q, sum_d;
    logic                 ovf_q, ovf_d;
    logic                 gnt_q, gnt_d;
    // Requester favoured on the next simultaneous request.
    logic                 prio_q, prio_d;
    logic                 done0_q, done0_d;
    logic                 done1_q, done1_d;
    logic [OVF_CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0] add_res;
    logic       add_ovf;
    logic       grant;
    logic       gnt_req;

    assign add_res = op1_q + op2_q;
    assign add_ovf = (op1_q[7] == op2_q[7]) && (add_res[7] != op1_q[7]);

    // Tie goes to the favoured requester; a lone request always wins.
    assign grant   = (req0 && req1) ? prio_q : req1;
    assign gnt_req = gnt_q ? req1 : req0;

    // Next-state and datapath update for the IDLE/EXEC/DONE controller.
    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        gnt_d   = gnt_q;
        prio_d  = prio_q;
        done0_d = done0_q;
        done1_d = done1_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (enable && (req0 || req1)) begin
                    gnt_d   = grant;
                    prio_d  = ~grant;
                    op1_d   = grant ? inp1_1 : inp1_0;
                    op2_d   = grant ? inp2_1 : inp2_0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                sum_d = add_res;
                ovf_d = add_ovf;
                if (add_ovf && (cnt_q != '1)) begin
                    cnt_d = cnt_q + OVF_CNT_W'(1);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                // done is registered one edge after DONE is entered, and
                // dropped on the edge that sees the granted req released.
                if (gnt_req) begin
                    done0_d = ~gnt_q;
                    done1_d = gnt_q;
                end else begin
                    done0_d = 1'b0;
                    done1_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            gnt_q   <= 1'b0;
            prio_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign done0         = done0_q;
    assign done1         = done1_q;
    assign sum           = sum_q;
    assign overflow_flag = ovf_q;
    assign gnt_id        = gnt_q;
    assign busy          = (state_q != S_IDLE);
    assign ovf_count     = cnt_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Scoreboard bench for add_arbiter: per-requester expected-result queues,
// a saturating overflow-count model for widths 8 and 2, and a grant log.
module tb_add_arbiter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       req0, req1;
    logic [7:0] inp1_0, inp2_0, inp1_1, inp2_1;
    logic       done0, done1, overflow_flag, gnt_id, busy;
    logic [7:0] sum;
    logic [7:0] ovf_count;
    logic       d2_done0, d2_done1, d2_ovf, d2_gnt, d2_busy;
    logic [7:0] d2_sum;
    logic [1:0] d2_ovf_count;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];
    int         grant_log[$];
    int         m_cnt8 = 0;
    int         m_cnt2 = 0;

    add_arbiter u_dut (
        .clk(clk), .reset(reset), .enable(enable), .req0(req0), .req1(req1),
        .inp1_0(inp1_0), .inp2_0(inp2_0), .inp1_1(inp1_1), .inp2_1(inp2_1),
        .done0(done0), .done1(done1), .sum(sum), .overflow_flag(overflow_flag),
        .gnt_id(gnt_id), .busy(busy), .ovf_count(ovf_count)
    );

    add_arbiter #(.OVF_CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .enable(enable), .req0(req0), .req1(req1),
        .inp1_0(inp1_0), .inp2_0(inp2_0), .inp1_1(inp1_1), .inp2_1(inp2_1),
        .done0(d2_done0), .done1(d2_done1), .sum(d2_sum), .overflow_flag(d2_ovf),
        .gnt_id(d2_gnt), .busy(d2_busy), .ovf_count(d2_ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One 4-phase transaction for requester r; lone=1 also checks latency
    // and scrambles the operands after the grant edge.
    task automatic run_req(input bit r, input logic [7:0] a, input logic [7:0] b, input bit lone);
        logic [7:0] es;
        logic       eo;
        logic [8:0] e;
        logic       d_self, d_other;
        int         n;
        bit         seen;
        es = a + b;
        eo = (a[7] == b[7]) && (es[7] != a[7]);
        @(negedge clk);
        if (r) begin
            exp_q1.push_back({eo, es});
            inp1_1 = a; inp2_1 = b; req1 = 1'b1;
        end else begin
            exp_q0.push_back({eo, es});
            inp1_0 = a; inp2_0 = b; req0 = 1'b1;
        end
        n = 0;
        seen = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (lone && n == 1) begin
                if (r) begin inp1_1 = ~a; inp2_1 = a ^ b; end
                else   begin inp1_0 = ~a; inp2_0 = a ^ b; end
            end
            d_self  = r ? done1 : done0;
            if (d_self) seen = 1;
        end
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            d_other = r ? done0 : done1;
            e = r ? exp_q1.pop_front() : exp_q0.pop_front();
            chk("sum", sum, e[7:0]);
            chk("overflow_flag", overflow_flag, e[8]);
            chk("gnt_id", gnt_id, r);
            chk("other_done_low", d_other, 0);
            chk("sum_w2", d2_sum, e[7:0]);
            if (lone) chk("latency", n, 3);
            if (e[8]) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            chk("ovf_count", ovf_count, m_cnt8);
            chk("ovf_count_w2", d2_ovf_count, m_cnt2);
            grant_log.push_back(r);
        end
        if (r) req1 = 1'b0; else req0 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            d_self = r ? done1 : done0;
        end while (d_self && n < 10);
        chk("done_release", d_self, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] last_sum;
        logic [7:0] ovf_a[5];
        logic [7:0] ovf_b[5];
        int         exp_gnt[4];
        reset = 1'b0; enable = 1'b1; req0 = 1'b0; req1 = 1'b0;
        inp1_0 = '0; inp2_0 = '0; inp1_1 = '0; inp2_1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_sum", sum, 0);
        chk("rst_ovf", overflow_flag, 0);
        chk("rst_done0", done0, 0);
        chk("rst_done1", done1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt_id, 0);
        chk("rst_ovf_count", ovf_count, 0);
        reset = 1'b1;

        run_req(0, 8'h01, 8'hFF, 1);
        run_req(1, 8'h7F, 8'h01, 1);

        ovf_a = '{8'h80, 8'h64, 8'h80, 8'h9C, 8'h40};
        ovf_b = '{8'h80, 8'h64, 8'hFF, 8'h9C, 8'h40};
        for (int i = 0; i < 5; i++) run_req(i[0], ovf_a[i], ovf_b[i], 1);
        run_req(0, 8'h12, 8'h34, 1);

        // Results hold while idle.
        last_sum = sum;
        repeat (3) @(negedge clk);
        chk("hold_sum", sum, last_sum);
        chk("hold_busy", busy, 0);

        // enable low blocks the grant, not the request.
        enable = 1'b0;
        inp1_0 = 8'h05; inp2_0 = 8'h06; req0 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("disabled_busy", busy, 0);
            chk("disabled_done0", done0, 0);
        end
        enable = 1'b1;
        @(negedge clk);
        chk("enable_grant_busy", busy, 1);
        chk("enable_grant_gnt", gnt_id, 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("enable_low_done0", done0, 1);
        chk("enable_low_sum", sum, 8'h0B);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("enable_low_release", done0, 0);
        enable = 1'b1;

        // Reset while in EXEC aborts with no done pulse.
        inp1_1 = 8'h7F; inp2_1 = 8'h7F; req1 = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_sum", sum, 0);
        chk("abort_ovf", overflow_flag, 0);
        chk("abort_done1", done1, 0);
        chk("abort_busy0", busy, 0);
        chk("abort_gnt", gnt_id, 0);
        chk("abort_ovf_count", ovf_count, 0);
        chk("abort_ovf_count_w2", d2_ovf_count, 0);
        m_cnt8 = 0;
        m_cnt2 = 0;
        reset = 1'b1;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_no_done", done1, 0);

        // Simultaneous requests after reset alternate starting with 0.
        grant_log.delete();
        fork
            begin
                run_req(0, 8'h80, 8'hFF, 0);
                run_req(0, 8'h11, 8'h22, 0);
            end
            begin
                run_req(1, 8'h7F, 8'h01, 0);
                run_req(1, 8'h01, 8'h01, 0);
            end
        join
        exp_gnt = '{0, 1, 0, 1};
        chk("grant_log_len", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) chk("grant_order", grant_log[i], exp_gnt[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
